// File: rtl/pcgen_pkg.sv
// rtl/pcgen_pkg.sv - shared types and constants for the program counter generator
package pcgen_pkg;

  localparam int XLEN                = 32;
  localparam int BTB_DEFAULT_ENTRIES = 16;

  // Redirect beat from execute/commit; target occupies the most significant bits.
  typedef struct packed {
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] branch_pc;
    logic            btb_update;
  } pcgen_redirect_t;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_OFFER = 1'b1
  } pcgen_state_t;

  // Fetch addresses are word aligned; the two low bits are always dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pcgen_btb.sv
// rtl/pcgen_btb.sv - direct-mapped branch target buffer with combinational lookup
module btb
  import pcgen_pkg::*;
#(
  parameter int ENTRIES = BTB_DEFAULT_ENTRIES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            hit,
  output logic [XLEN-1:0] hit_target,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [TAGW-1:0]    r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];

  logic [IDX-1:0]  w_lk_idx;
  logic [TAGW-1:0] w_lk_tag;
  logic [IDX-1:0]  w_up_idx;
  logic [TAGW-1:0] w_up_tag;
  logic            w_unused_bits;

  assign w_lk_idx = lookup_pc[IDX+1:2];
  assign w_lk_tag = lookup_pc[XLEN-1:IDX+2];
  assign w_up_idx = upd_pc[IDX+1:2];
  assign w_up_tag = upd_pc[XLEN-1:IDX+2];

  // Byte offset bits never participate in indexing or tagging.
  assign w_unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Reads use the registered contents, so a same-cycle write is not visible yet.
  assign hit        = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign hit_target = r_target[w_lk_idx];

  // Valid bits: cleared by reset, set by every update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (upd_en) begin
      r_valid[w_up_idx] <= 1'b1;
    end
  end

  // Tag and target payload; meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && upd_en) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/pcgen.sv
// rtl/pcgen.sv - next fetch address generator with redirect, BTB and PC+4 priority
module pcgen
  import pcgen_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_ENTRIES  = BTB_DEFAULT_ENTRIES
) (
  input  logic                           clk,
  input  logic                           rst,
  // next fetch address towards the fetch unit
  output logic                           o_next_pc_tvalid,
  output logic [XLEN-1:0]                o_next_pc_tdata,
  input  logic                           i_next_pc_tready,
  // fetch unit's current PC
  input  logic                           i_current_pc_tvalid,
  input  logic [XLEN-1:0]                i_current_pc_tdata,
  output logic                           o_current_pc_tready,
  // redirect and BTB update from later stages
  input  logic                           i_redirect_tvalid,
  input  logic [$bits(pcgen_redirect_t)-1:0] i_redirect_tdata,
  output logic                           o_redirect_tready,
  // IF/ID flush pulse
  output logic                           invalidate
);

  pcgen_state_t    r_state, w_state_n;
  logic [XLEN-1:0] r_next_pc_q, w_next_pc_n;
  logic            r_pending, w_pending_n;
  logic [XLEN-1:0] r_pending_tgt, w_pending_tgt_n;
  logic            r_invalidate;
  logic            r_fresh;

  pcgen_redirect_t w_redirect;
  logic            w_handshake;
  logic            w_btb_hit;
  logic [XLEN-1:0] w_btb_target;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_candidate;
  logic            w_unused;

  assign w_redirect  = i_redirect_tdata;
  assign w_handshake = (r_state == ST_OFFER) && i_next_pc_tready;
  assign w_pc_plus4  = i_current_pc_tdata + XLEN'(4);
  assign w_unused    = i_current_pc_tvalid;

  assign o_current_pc_tready = 1'b1;
  assign o_redirect_tready   = 1'b1;
  assign o_next_pc_tvalid    = (r_state == ST_OFFER);
  assign o_next_pc_tdata     = r_next_pc_q;
  assign invalidate          = r_invalidate;

  btb #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lookup_pc  (i_current_pc_tdata),
    .hit        (w_btb_hit),
    .hit_target (w_btb_target),
    .upd_en     (i_redirect_tvalid && w_redirect.btb_update),
    .upd_pc     (w_redirect.branch_pc),
    .upd_target (w_redirect.target)
  );

  // Candidate priority: fresh redirect, then a held redirect, then BTB, then sequential.
  always_comb begin
    w_candidate = w_pc_plus4;
    if (i_redirect_tvalid) begin
      w_candidate = w_redirect.target;
    end else if (r_pending) begin
      w_candidate = r_pending_tgt;
    end else if (w_btb_hit) begin
      w_candidate = w_btb_target;
    end
  end

  // Next-state logic: FILL computes an address, OFFER holds it until the fetch unit takes it.
  always_comb begin
    w_state_n       = r_state;
    w_next_pc_n     = r_next_pc_q;
    w_pending_n     = r_pending;
    w_pending_tgt_n = r_pending_tgt;
    case (r_state)
      ST_FILL: begin
        w_next_pc_n = align_pc(w_candidate);
        w_pending_n = 1'b0;
        w_state_n   = ST_OFFER;
      end
      ST_OFFER: begin
        if (w_handshake) begin
          w_state_n = ST_FILL;
          // The offer just left, so a colliding redirect waits for the next FILL.
          if (i_redirect_tvalid) begin
            w_pending_n     = 1'b1;
            w_pending_tgt_n = w_redirect.target;
          end
        end else if (i_redirect_tvalid) begin
          // Overwriting data under tvalid is tolerated only on this link.
          w_next_pc_n = align_pc(w_redirect.target);
        end
      end
      default: begin
        w_state_n = ST_FILL;
      end
    endcase
  end

  // State and datapath registers; reset discards any pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_FILL;
      r_next_pc_q   <= '0;
      r_pending     <= 1'b0;
      r_pending_tgt <= '0;
      r_invalidate  <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_next_pc_q   <= w_next_pc_n;
      r_pending     <= w_pending_n;
      r_pending_tgt <= w_pending_tgt_n;
      r_invalidate  <= i_redirect_tvalid;
    end
  end

  // Marks the first cycle out of reset, when the fetch unit must hold RESET_VECTOR.
  always_ff @(posedge clk) begin
    r_fresh <= rst;
  end

  // Consistency check of the fetch unit's post-reset PC.
  always_ff @(posedge clk) begin
    if (!rst && r_fresh) begin
      assert (i_current_pc_tdata == RESET_VECTOR);
    end
  end

endmodule
